// File: rtl/branch_target_buffer_if.sv
// branch_target_buffer_if
//   Bundles the fetch-side lookup, the decode-side resolve/update and the
//   decode prediction outputs of the branch target buffer.
//   master : pipeline side; drives PCF, StallD, FlushD, UpdateD, PCD, TakenD
//            and TargetD, and receives the predictions.
//   slave  : branch_target_buffer side.
//   Handshake: there is none. Every input is sampled each cycle; UpdateD
//   qualifies PCD/TakenD/TargetD, and the BTB never back-pressures.
interface branch_target_buffer_if;
  logic [31:0] PCF;
  logic        StallD;
  logic        FlushD;
  logic        UpdateD;
  logic [31:0] PCD;
  logic        TakenD;
  logic [31:0] TargetD;
  logic        PreBr;
  logic [31:0] PCPredictF;
  logic        PredTakenD;
  logic [31:0] PredTargetD;
  logic        MispredictD;

  modport master (
    output PCF, StallD, FlushD, UpdateD, PCD, TakenD, TargetD,
    input  PreBr, PCPredictF, PredTakenD, PredTargetD, MispredictD
  );

  modport slave (
    input  PCF, StallD, FlushD, UpdateD, PCD, TakenD, TargetD,
    output PreBr, PCPredictF, PredTakenD, PredTargetD, MispredictD
  );
endinterface

// File: rtl/branch_target_buffer.sv
// branch_target_buffer
//   Direct-mapped BTB with 2-bit saturating direction counters. Looks up the
//   fetch PC combinationally, learns from branches resolved in decode (one
//   entry per cycle) and carries the fetch prediction into decode so that a
//   mispredict can be flagged there.
//   Ports:
//     clk   : clock, all state changes on the rising edge
//     rst_n : asynchronous active-low reset
//     bus   : branch_target_buffer_if.slave (lookup, update, decode preds)
module branch_target_buffer #(
  parameter int ENTRIES    = 16,
  parameter int INDEX_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  branch_target_buffer_if.slave bus
);

  localparam int TAG_W = 32 - INDEX_BITS - 2;

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [31:0]       target_q [ENTRIES];
  logic [1:0]        ctr_q    [ENTRIES];

  logic [INDEX_BITS-1:0] idx_f, idx_d;
  logic [TAG_W-1:0]      tag_f, tag_d;
  logic                  hit_f, hit_d;

  logic        wr_en;
  logic [1:0]  ctr_d;
  logic [31:0] target_d;

  logic        pred_taken_q, pred_taken_d;
  logic [31:0] pred_target_q, pred_target_d;

  // Byte-offset bits of both PCs carry no information for word-aligned code.
  logic unused_low_bits;
  assign unused_low_bits = ^{bus.PCF[1:0], bus.PCD[1:0]};

  assign idx_f = bus.PCF[INDEX_BITS+1:2];
  assign tag_f = bus.PCF[31:INDEX_BITS+2];
  assign idx_d = bus.PCD[INDEX_BITS+1:2];
  assign tag_d = bus.PCD[31:INDEX_BITS+2];

  assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign hit_d = valid_q[idx_d] && (tag_q[idx_d] == tag_d);

  // Lookup reads the registered arrays, so a same-cycle update to the same
  // index is only visible from the following cycle.
  assign bus.PreBr      = hit_f && ctr_q[idx_f][1];
  assign bus.PCPredictF = hit_f ? target_q[idx_f] : 32'h0;

  // Next contents of the entry selected by PCD.
  always_comb begin
    wr_en    = 1'b0;
    ctr_d    = ctr_q[idx_d];
    target_d = target_q[idx_d];
    if (bus.UpdateD) begin
      if (hit_d) begin
        wr_en = 1'b1;
        if (bus.TakenD) begin
          ctr_d    = (ctr_q[idx_d] == 2'b11) ? 2'b11 : ctr_q[idx_d] + 2'b01;
          target_d = bus.TargetD;
        end else begin
          ctr_d    = (ctr_q[idx_d] == 2'b00) ? 2'b00 : ctr_q[idx_d] - 2'b01;
        end
      end else if (bus.TakenD) begin
        // Allocation replaces the whole entry, weakly taken.
        wr_en    = 1'b1;
        ctr_d    = 2'b10;
        target_d = bus.TargetD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= 32'h0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (wr_en) begin
      valid_q[idx_d]  <= 1'b1;
      tag_q[idx_d]    <= tag_d;
      target_q[idx_d] <= target_d;
      ctr_q[idx_d]    <= ctr_d;
    end
  end

  // Decode prediction registers: flush has priority over stall.
  always_comb begin
    pred_taken_d  = bus.PreBr;
    pred_target_d = bus.PCPredictF;
    if (bus.FlushD) begin
      pred_taken_d  = 1'b0;
      pred_target_d = 32'h0;
    end else if (bus.StallD) begin
      pred_taken_d  = pred_taken_q;
      pred_target_d = pred_target_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_taken_q  <= 1'b0;
      pred_target_q <= 32'h0;
    end else begin
      pred_taken_q  <= pred_taken_d;
      pred_target_q <= pred_target_d;
    end
  end

  assign bus.PredTakenD  = pred_taken_q;
  assign bus.PredTargetD = pred_target_q;

  // A not-taken resolve only checks direction; a taken one also checks target.
  assign bus.MispredictD = bus.UpdateD &&
                           ((bus.TakenD != pred_taken_q) ||
                            (bus.TakenD && (pred_target_q != bus.TargetD)));

endmodule

// File: tb/tb_branch_target_buffer.sv
// tb_branch_target_buffer
//   Directed, table-driven bench for branch_target_buffer (ENTRIES=16).
//   Each table row is one clock cycle: inputs applied after the falling edge,
//   outputs compared 1 ns later, state advancing on the next rising edge.
module tb_branch_target_buffer;

  logic clk;
  logic rst_n;

  branch_target_buffer_if bus ();

  branch_target_buffer #(.ENTRIES(16), .INDEX_BITS(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pcf;
    logic        upd;
    logic [31:0] pcd;
    logic        taken;
    logic [31:0] tgt;
    logic        stall;
    logic        flush;
    logic        e_prebr;
    logic [31:0] e_pcp;
    logic        e_ptd;
    logic [31:0] e_ptgt;
    logic        e_mis;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic add(input logic [31:0] pcf, input logic upd,
                     input logic [31:0] pcd, input logic taken,
                     input logic [31:0] tgt, input logic stall,
                     input logic flush, input logic e_prebr,
                     input logic [31:0] e_pcp, input logic e_ptd,
                     input logic [31:0] e_ptgt, input logic e_mis);
    vec_t v;
    v.pcf = pcf; v.upd = upd; v.pcd = pcd; v.taken = taken; v.tgt = tgt;
    v.stall = stall; v.flush = flush; v.e_prebr = e_prebr; v.e_pcp = e_pcp;
    v.e_ptd = e_ptd; v.e_ptgt = e_ptgt; v.e_mis = e_mis;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.PCF     = v.pcf;
    bus.UpdateD = v.upd;
    bus.PCD     = v.pcd;
    bus.TakenD  = v.taken;
    bus.TargetD = v.tgt;
    bus.StallD  = v.stall;
    bus.FlushD  = v.flush;
  endtask

  task automatic check_outputs(input string tag, input logic e_prebr,
                               input logic [31:0] e_pcp, input logic e_ptd,
                               input logic [31:0] e_ptgt, input logic e_mis);
    check({tag, " PreBr"},       {31'h0, bus.PreBr},       {31'h0, e_prebr});
    check({tag, " PCPredictF"},  bus.PCPredictF,           e_pcp);
    check({tag, " PredTakenD"},  {31'h0, bus.PredTakenD},  {31'h0, e_ptd});
    check({tag, " PredTargetD"}, bus.PredTargetD,          e_ptgt);
    check({tag, " MispredictD"}, {31'h0, bus.MispredictD}, {31'h0, e_mis});
  endtask

  initial begin
    // Table: pcf, upd, pcd, taken, tgt, stall, flush |
    //        PreBr, PCPredictF, PredTakenD, PredTargetD, MispredictD
    // Cold lookup, then cold taken branch 0x40 -> 0x100 (ctr=2).
    add(32'h40, 0, 32'h0,  0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h0,   0);
    add(32'h0,  1, 32'h40, 1, 32'h100, 0, 0, 0, 32'h0,   0, 32'h0,   1);
    add(32'h40, 0, 32'h0,  0, 32'h0,   0, 0, 1, 32'h100, 0, 32'h0,   0);
    // Hysteresis: not-taken -> ctr1 (PreBr 0, target still reported).
    add(32'h40, 1, 32'h40, 0, 32'h0,   0, 0, 1, 32'h100, 1, 32'h100, 1);
    add(32'h40, 0, 32'h0,  0, 32'h0,   0, 0, 0, 32'h100, 1, 32'h100, 0);
    // Taken x3 -> ctr2, ctr3, ctr3 (saturated).
    add(32'h40, 1, 32'h40, 1, 32'h100, 0, 0, 0, 32'h100, 0, 32'h100, 1);
    add(32'h40, 1, 32'h40, 1, 32'h100, 0, 0, 1, 32'h100, 0, 32'h100, 1);
    add(32'h40, 1, 32'h40, 1, 32'h100, 0, 0, 1, 32'h100, 1, 32'h100, 0);
    // Not-taken x2 -> ctr2 (PreBr stays 1), ctr1.
    add(32'h40, 1, 32'h40, 0, 32'h0,   0, 0, 1, 32'h100, 1, 32'h100, 1);
    add(32'h40, 1, 32'h40, 0, 32'h0,   0, 0, 1, 32'h100, 1, 32'h100, 1);
    add(32'h40, 0, 32'h0,  0, 32'h0,   0, 0, 0, 32'h100, 1, 32'h100, 0);
    // Not-taken x2 -> ctr0, ctr0 (saturated low).
    add(32'h40, 1, 32'h40, 0, 32'h0,   0, 0, 0, 32'h100, 0, 32'h100, 0);
    add(32'h40, 1, 32'h40, 0, 32'h0,   0, 0, 0, 32'h100, 0, 32'h100, 0);
    // Taken x2 -> ctr1, ctr2.
    add(32'h40, 1, 32'h40, 1, 32'h100, 0, 0, 0, 32'h100, 0, 32'h100, 1);
    add(32'h40, 1, 32'h40, 1, 32'h100, 0, 0, 0, 32'h100, 0, 32'h100, 1);
    add(32'h40, 0, 32'h0,  0, 32'h0,   0, 0, 1, 32'h100, 0, 32'h100, 0);
    // Aliasing: 0x440 shares index 0; replace entry, 0x40 then misses.
    add(32'h440, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,   1, 32'h100, 0);
    add(32'h440, 1, 32'h440, 1, 32'h200, 0, 0, 0, 32'h0,   0, 32'h0,   1);
    add(32'h40,  0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h0,   0);
    add(32'h440, 0, 32'h0,   0, 32'h0,   0, 0, 1, 32'h200, 0, 32'h0,   0);
    // Not-taken miss (0x840) allocates nothing, leaves 0x440 intact.
    add(32'h440, 1, 32'h840, 0, 32'h0,   0, 0, 1, 32'h200, 1, 32'h200, 1);
    add(32'h440, 0, 32'h0,   0, 32'h0,   0, 0, 1, 32'h200, 1, 32'h200, 0);
    add(32'h840, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,   1, 32'h200, 0);
    // Low PC bits ignored.
    add(32'h443, 0, 32'h0,   0, 32'h0,   0, 0, 1, 32'h200, 0, 32'h0,   0);
    // Same-cycle update/lookup on 0x80: old outputs now, new next cycle.
    add(32'h80, 1, 32'h80, 1, 32'h300, 0, 0, 0, 32'h0,   1, 32'h200, 1);
    add(32'h80, 0, 32'h0,  0, 32'h0,   0, 0, 1, 32'h300, 0, 32'h0,   0);
    // Decode registers: train 0x44 -> 0x100, then stall / flush.
    add(32'h0,  1, 32'h44, 1, 32'h100, 0, 0, 0, 32'h0,   1, 32'h300, 1);
    add(32'h44, 0, 32'h0,  0, 32'h0,   1, 0, 1, 32'h100, 0, 32'h0,   0);
    add(32'h44, 0, 32'h0,  0, 32'h0,   0, 0, 1, 32'h100, 0, 32'h0,   0);
    add(32'h0,  0, 32'h0,  0, 32'h0,   1, 0, 0, 32'h0,   1, 32'h100, 0);
    add(32'h44, 0, 32'h0,  0, 32'h0,   1, 1, 1, 32'h100, 1, 32'h100, 0);
    add(32'h44, 0, 32'h0,  0, 32'h0,   0, 0, 1, 32'h100, 0, 32'h0,   0);
    // Correct taken resolve, then wrong target (retargets entry to 0x104).
    add(32'h44, 1, 32'h44, 1, 32'h100, 0, 0, 1, 32'h100, 1, 32'h100, 0);
    add(32'h44, 1, 32'h44, 1, 32'h104, 0, 0, 1, 32'h100, 1, 32'h100, 1);
    add(32'h44, 0, 32'h0,  0, 32'h0,   0, 0, 1, 32'h104, 1, 32'h100, 0);
    add(32'h44, 0, 32'h0,  0, 32'h0,   0, 1, 1, 32'h104, 1, 32'h104, 0);
    add(32'h44, 0, 32'h0,  0, 32'h0,   0, 0, 1, 32'h104, 0, 32'h0,   0);

    // Reset state, checked while reset is held.
    rst_n       = 1'b0;
    bus.PCF     = 32'h40;
    bus.UpdateD = 1'b0;
    bus.PCD     = 32'h0;
    bus.TakenD  = 1'b0;
    bus.TargetD = 32'h0;
    bus.StallD  = 1'b0;
    bus.FlushD  = 1'b0;
    #2;
    check_outputs("reset", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].e_prebr, vecs[i].e_pcp,
                    vecs[i].e_ptd, vecs[i].e_ptgt, vecs[i].e_mis);
    end

    // Asynchronous reset mid-run: trained entry vanishes with no clock edge.
    @(negedge clk);
    bus.PCF     = 32'h44;
    bus.UpdateD = 1'b0;
    bus.StallD  = 1'b0;
    bus.FlushD  = 1'b0;
    #1;
    check("pre_rst PreBr", {31'h0, bus.PreBr}, 32'h1);
    check("pre_rst PCPredictF", bus.PCPredictF, 32'h104);
    #1 rst_n = 1'b0;
    #1;
    check_outputs("async_rst", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.PCF = 32'h44;
    #1;
    check("post_rst PreBr", {31'h0, bus.PreBr}, 32'h0);
    check("post_rst PCPredictF", bus.PCPredictF, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
